// File: rtl/timer_key_sequencer.sv
// Key sequencer and control FSM for the time-of-day / countdown timer.
// Debounces the three pushbuttons, makes the 1 Hz tick and blink phase,
// and issues one-cycle command strobes plus display selects to the
// BCD counter/display datapath.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   key_*_n               raw active-low pushbuttons (asynchronous)
//   cnt_zero              countdown datapath reads 00:00:00
//   disp_sel              0=ID 1=time of day 2=countdown 3=preset
//   edit_field            0=none 1=sec 2=min 3=hr
//   blink                 blank edited field (all digits when done)
//   tod_tick, dec_strobe, inc_strobe, clr_sec_strobe, load_strobe
//                         one-cycle datapath commands
//   alarm_on              countdown expired
module timer_key_sequencer #(
    parameter int CLK_HZ       = 50000000,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int BLINK_CYC    = 25000000,
    parameter int ID_CYC       = 100000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_adjust_n,
    input  logic       key_start_stop_n,
    input  logic       key_mode_n,
    input  logic       cnt_zero,
    output logic [1:0] disp_sel,
    output logic [1:0] edit_field,
    output logic       blink,
    output logic       tod_tick,
    output logic       dec_strobe,
    output logic       inc_strobe,
    output logic       clr_sec_strobe,
    output logic       load_strobe,
    output logic       alarm_on
);

    localparam int CW = $clog2(CLK_HZ + 1);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int BW = $clog2(BLINK_CYC + 1);
    localparam int IW = $clog2(ID_CYC + 1);

    typedef enum logic [3:0] {
        S_ID, S_TOD, S_TE_SEC, S_TE_MIN, S_TE_HR,
        S_CD_IDLE, S_CD_RUN, S_CD_PAUSE,
        S_CE_MIN, S_CE_HR, S_CD_DONE
    } state_e;

    // Key bit order everywhere: [0]=adjust [1]=start_stop [2]=mode
    logic [2:0]    sync1_q, sync2_q, db_q, press_q;
    logic [DW-1:0] deb_cnt_q [3];

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
            db_q    <= 3'b111;
            press_q <= 3'b000;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q <= {key_mode_n, key_start_stop_n, key_adjust_n};
            sync2_q <= sync1_q;
            for (int i = 0; i < 3; i++) begin
                press_q[i] <= 1'b0;
                if (sync2_q[i] != db_q[i]) begin
                    if (deb_cnt_q[i] == DW'(DEBOUNCE_CYC - 1)) begin
                        deb_cnt_q[i] <= '0;
                        db_q[i]      <= sync2_q[i];
                        // Only the accepted 1->0 level change is a press
                        press_q[i]   <= ~sync2_q[i];
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                    end
                end else begin
                    deb_cnt_q[i] <= '0;
                end
            end
        end
    end

    // Same-cycle events resolve mode > start_stop > adjust
    logic ev_mode, ev_ss, ev_adj;
    assign ev_mode = press_q[2];
    assign ev_ss   = press_q[1] & ~press_q[2];
    assign ev_adj  = press_q[0] & ~press_q[1] & ~press_q[2];

    state_e        state_q, state_d;
    logic [CW-1:0] tick_cnt_q;
    logic [IW-1:0] id_cnt_q;
    logic [BW-1:0] blink_cnt_q;
    logic          tick;
    logic          inc_d, clr_d, load_d, dec_d, tod_d;
    logic [1:0]    disp_d, field_d;
    logic          tod_edit, blink_en;

    assign tick     = (tick_cnt_q == CW'(CLK_HZ - 1));
    assign tod_edit = state_q inside {S_TE_SEC, S_TE_MIN, S_TE_HR};
    assign blink_en = state_q inside {S_TE_SEC, S_TE_MIN, S_TE_HR,
                                      S_CE_MIN, S_CE_HR, S_CD_DONE};

    always_comb begin
        state_d = state_q;
        inc_d   = 1'b0;
        clr_d   = 1'b0;
        load_d  = 1'b0;
        dec_d   = 1'b0;
        tod_d   = tick & ~tod_edit;
        unique case (state_q)
            S_ID: begin
                if (id_cnt_q == IW'(ID_CYC - 1)) state_d = S_TOD;
            end
            S_TOD: begin
                if (ev_mode)     state_d = S_CD_IDLE;
                else if (ev_adj) state_d = S_TE_SEC;
            end
            S_TE_SEC: begin
                if (ev_ss)        clr_d   = 1'b1;
                else if (ev_mode) state_d = S_TE_MIN;
                else if (ev_adj)  state_d = S_TOD;
            end
            S_TE_MIN: begin
                if (ev_ss)        inc_d   = 1'b1;
                else if (ev_mode) state_d = S_TE_HR;
                else if (ev_adj)  state_d = S_TOD;
            end
            S_TE_HR: begin
                if (ev_ss)        inc_d   = 1'b1;
                else if (ev_mode) state_d = S_TE_SEC;
                else if (ev_adj)  state_d = S_TOD;
            end
            S_CD_IDLE: begin
                if (ev_mode)                 state_d = S_TOD;
                else if (ev_ss && !cnt_zero) state_d = S_CD_RUN;
                else if (ev_adj)             state_d = S_CE_MIN;
            end
            S_CD_RUN: begin
                // A tick swallows any key event in the same cycle
                if (tick) begin
                    if (cnt_zero) state_d = S_CD_DONE;
                    else          dec_d   = 1'b1;
                end else if (ev_ss) begin
                    state_d = S_CD_PAUSE;
                end else if (ev_adj) begin
                    load_d  = 1'b1;
                    state_d = S_CD_IDLE;
                end
            end
            S_CD_PAUSE: begin
                if (ev_ss) begin
                    state_d = S_CD_RUN;
                end else if (ev_adj) begin
                    load_d  = 1'b1;
                    state_d = S_CD_IDLE;
                end
            end
            S_CE_MIN, S_CE_HR: begin
                if (ev_ss) begin
                    inc_d = 1'b1;
                end else if (ev_mode) begin
                    state_d = (state_q == S_CE_MIN) ? S_CE_HR : S_CE_MIN;
                end else if (ev_adj) begin
                    load_d  = 1'b1;
                    state_d = S_CD_IDLE;
                end
            end
            S_CD_DONE: begin
                if (ev_mode || ev_ss || ev_adj) begin
                    load_d  = 1'b1;
                    state_d = S_CD_IDLE;
                end
            end
            default: state_d = S_ID;
        endcase

        disp_d  = 2'd2;
        field_d = 2'd0;
        unique case (state_d)
            S_ID:     disp_d = 2'd0;
            S_TOD:    disp_d = 2'd1;
            S_TE_SEC: begin disp_d = 2'd1; field_d = 2'd1; end
            S_TE_MIN: begin disp_d = 2'd1; field_d = 2'd2; end
            S_TE_HR:  begin disp_d = 2'd1; field_d = 2'd3; end
            S_CE_MIN: begin disp_d = 2'd3; field_d = 2'd2; end
            S_CE_HR:  begin disp_d = 2'd3; field_d = 2'd3; end
            default:  disp_d = 2'd2;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_ID;
            tick_cnt_q     <= '0;
            id_cnt_q       <= '0;
            blink_cnt_q    <= '0;
            blink          <= 1'b0;
            disp_sel       <= 2'd0;
            edit_field     <= 2'd0;
            tod_tick       <= 1'b0;
            dec_strobe     <= 1'b0;
            inc_strobe     <= 1'b0;
            clr_sec_strobe <= 1'b0;
            load_strobe    <= 1'b0;
            alarm_on       <= 1'b0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            if (state_q == S_ID) id_cnt_q <= id_cnt_q + 1'b1;
            state_q <= state_d;
            // New state restarts the blink so the new field shows first
            if (state_d != state_q) begin
                blink_cnt_q <= '0;
                blink       <= 1'b0;
            end else if (blink_en) begin
                if (blink_cnt_q == BW'(BLINK_CYC - 1)) begin
                    blink_cnt_q <= '0;
                    blink       <= ~blink;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end
            disp_sel       <= disp_d;
            edit_field     <= field_d;
            tod_tick       <= tod_d;
            dec_strobe     <= dec_d;
            inc_strobe     <= inc_d;
            clr_sec_strobe <= clr_d;
            load_strobe    <= load_d;
            alarm_on       <= (state_d == S_CD_DONE);
        end
    end

endmodule

// File: tb/tb_timer_key_sequencer.sv
// Scoreboard bench for timer_key_sequencer: directed key sequences then
// random key/cnt_zero/reset traffic against a table-driven reference model.
`timescale 1ns/1ps
module tb_timer_key_sequencer;

    localparam int CLK_HZ = 10;
    localparam int DEB    = 4;
    localparam int BLINKC = 5;
    localparam int IDC    = 8;

    // Reference model modes
    localparam int M_ID = 0, M_TOD = 1, M_TSEC = 2, M_TMIN = 3, M_THR = 4;
    localparam int M_CDI = 5, M_RUN = 6, M_PAU = 7, M_CMIN = 8, M_CHR = 9;
    localparam int M_DONE = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       key_adjust_n = 1'b1;
    logic       key_start_stop_n = 1'b1;
    logic       key_mode_n = 1'b1;
    logic       cnt_zero = 1'b0;
    logic [1:0] disp_sel, edit_field;
    logic       blink, tod_tick, dec_strobe, inc_strobe;
    logic       clr_sec_strobe, load_strobe, alarm_on;

    timer_key_sequencer #(
        .CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DEB),
        .BLINK_CYC(BLINKC), .ID_CYC(IDC)
    ) dut (
        .clock(clock), .reset(reset),
        .key_adjust_n(key_adjust_n),
        .key_start_stop_n(key_start_stop_n),
        .key_mode_n(key_mode_n),
        .cnt_zero(cnt_zero),
        .disp_sel(disp_sel), .edit_field(edit_field),
        .blink(blink), .tod_tick(tod_tick),
        .dec_strobe(dec_strobe), .inc_strobe(inc_strobe),
        .clr_sec_strobe(clr_sec_strobe),
        .load_strobe(load_strobe), .alarm_on(alarm_on)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] disp;
        logic [1:0] field;
        logic       blk, tt, dec, inc, clr, load, alarm;
    } exp_t;

    exp_t expq[$];
    int checks = 0;
    int failures = 0;
    int n_clr = 0, n_inc = 0, n_load = 0, n_dec = 0;

    int disp_of[11]  = '{0, 1, 1, 1, 1, 2, 2, 2, 3, 3, 2};
    int field_of[11] = '{0, 0, 1, 2, 3, 0, 0, 0, 2, 3, 0};

    // Stimulus levels applied by step()
    bit rst_v = 1'b1;
    bit raw_v[3] = '{1'b1, 1'b1, 1'b1};
    bit cz_v = 1'b0;

    // Model: key delay line, debounced level, run length, pending press
    int m_s1[3], m_s2[3], m_db[3], m_run[3];
    bit m_ev[3];
    int m_tc, m_id, m_mode, m_bc;
    bit m_bph;

    task automatic chk(input string name, input logic [3:0] got,
                       input logic [3:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
        end
    endtask

    function automatic bit blinks(input int md);
        return md inside {M_TSEC, M_TMIN, M_THR, M_CMIN, M_CHR, M_DONE};
    endfunction

    task automatic model_step(input bit rst, input bit cz);
        exp_t e;
        int ev, nm;
        bit tick, inc, clr, load, dec, tt, nev;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_s1[k] = 1; m_s2[k] = 1; m_db[k] = 1;
                m_run[k] = 0; m_ev[k] = 0;
            end
            m_tc = 0; m_id = 0; m_mode = M_ID; m_bc = 0; m_bph = 0;
            e = '0;
            expq.push_back(e);
            return;
        end
        tick = (m_tc == CLK_HZ - 1);
        ev = -1;
        if (m_ev[2]) ev = 2;
        else if (m_ev[1]) ev = 1;
        else if (m_ev[0]) ev = 0;
        nm = m_mode;
        inc = 0; clr = 0; load = 0; dec = 0;
        case (m_mode)
            M_ID:   if (m_id + 1 == IDC) nm = M_TOD;
            M_TOD:  if (ev == 2) nm = M_CDI; else if (ev == 0) nm = M_TSEC;
            M_TSEC, M_TMIN, M_THR: begin
                if (ev == 1) begin
                    if (m_mode == M_TSEC) clr = 1; else inc = 1;
                end else if (ev == 2) begin
                    nm = (m_mode == M_THR) ? M_TSEC : m_mode + 1;
                end else if (ev == 0) begin
                    nm = M_TOD;
                end
            end
            M_CDI: begin
                if (ev == 2) nm = M_TOD;
                else if (ev == 1 && !cz) nm = M_RUN;
                else if (ev == 0) nm = M_CMIN;
            end
            M_RUN: begin
                if (tick) begin
                    if (cz) nm = M_DONE; else dec = 1;
                end else if (ev == 1) nm = M_PAU;
                else if (ev == 0) begin load = 1; nm = M_CDI; end
            end
            M_PAU: begin
                if (ev == 1) nm = M_RUN;
                else if (ev == 0) begin load = 1; nm = M_CDI; end
            end
            M_CMIN, M_CHR: begin
                if (ev == 1) inc = 1;
                else if (ev == 2) nm = (m_mode == M_CMIN) ? M_CHR : M_CMIN;
                else if (ev == 0) begin load = 1; nm = M_CDI; end
            end
            M_DONE: if (ev >= 0) begin load = 1; nm = M_CDI; end
            default: nm = M_ID;
        endcase
        tt = tick && !(m_mode inside {M_TSEC, M_TMIN, M_THR});
        if (m_mode == M_ID) m_id++;
        if (nm != m_mode) begin
            m_bc = 0; m_bph = 0;
        end else if (blinks(m_mode)) begin
            m_bc++;
            if (m_bc == BLINKC) begin m_bc = 0; m_bph = !m_bph; end
        end
        for (int k = 0; k < 3; k++) begin
            nev = 0;
            if (m_s2[k] != m_db[k]) begin
                m_run[k]++;
                if (m_run[k] == DEB) begin
                    m_db[k] = m_s2[k]; m_run[k] = 0; nev = (m_s2[k] == 0);
                end
            end else begin
                m_run[k] = 0;
            end
            m_ev[k] = nev;
            m_s2[k] = m_s1[k];
            m_s1[k] = raw_v[k];
        end
        m_tc = tick ? 0 : m_tc + 1;
        m_mode = nm;
        e.disp = 2'(disp_of[nm]);
        e.field = 2'(field_of[nm]);
        e.blk = m_bph; e.tt = tt; e.dec = dec; e.inc = inc;
        e.clr = clr; e.load = load; e.alarm = (nm == M_DONE);
        expq.push_back(e);
    endtask

    task automatic step();
        @(negedge clock);
        reset = rst_v;
        key_adjust_n = raw_v[0];
        key_start_stop_n = raw_v[1];
        key_mode_n = raw_v[2];
        cnt_zero = cz_v;
        model_step(rst_v, cz_v);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // mask bit k holds key k low for 'hold' cycles, then releases it
    task automatic press(input bit [2:0] mask, input int hold);
        for (int k = 0; k < 3; k++) if (mask[k]) raw_v[k] = 1'b0;
        run(hold);
        for (int k = 0; k < 3; k++) raw_v[k] = 1'b1;
        run(10);
    endtask

    // Monitor: one expected output vector per clock
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("disp_sel", 4'(disp_sel), 4'(e.disp));
                chk("edit_field", 4'(edit_field), 4'(e.field));
                chk("blink", 4'(blink), 4'(e.blk));
                chk("tod_tick", 4'(tod_tick), 4'(e.tt));
                chk("dec_strobe", 4'(dec_strobe), 4'(e.dec));
                chk("inc_strobe", 4'(inc_strobe), 4'(e.inc));
                chk("clr_sec_strobe", 4'(clr_sec_strobe), 4'(e.clr));
                chk("load_strobe", 4'(load_strobe), 4'(e.load));
                chk("alarm_on", 4'(alarm_on), 4'(e.alarm));
                n_clr += int'(clr_sec_strobe);
                n_inc += int'(inc_strobe);
                n_load += int'(load_strobe);
                n_dec += int'(dec_strobe);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, i0, d0, l0;
        rst_v = 1'b1;
        run(2);
        rst_v = 1'b0;
        run(30);
        chk("id_to_tod", 4'(disp_sel), 4'd1);

        // Short bounce on mode, then a real press
        raw_v[2] = 1'b0; run(3); raw_v[2] = 1'b1; run(10);
        chk("bounce_ignored", 4'(disp_sel), 4'd1);
        press(3'b100, 10);
        chk("mode_to_cd", 4'(disp_sel), 4'd2);
        press(3'b100, 8);

        // Time-of-day edit walk
        c0 = n_clr; i0 = n_inc;
        press(3'b001, 8);
        chk("te_sec_field", 4'(edit_field), 4'd1);
        press(3'b010, 8);
        press(3'b100, 8);
        chk("te_min_field", 4'(edit_field), 4'd2);
        press(3'b010, 8);
        press(3'b010, 8);
        press(3'b001, 8);
        chk("clr_count", 4'(n_clr - c0), 4'd1);
        chk("inc_count", 4'(n_inc - i0), 4'd2);
        chk("edit_exit", 4'(disp_sel), 4'd1);

        // Mode and adjust together: mode wins
        press(3'b101, 8);
        chk("prio_disp", 4'(disp_sel), 4'd2);
        chk("prio_field", 4'(edit_field), 4'd0);

        // Preset edit then reset from CE_HR
        press(3'b001, 8);
        press(3'b100, 8);
        chk("ce_hr_disp", 4'(disp_sel), 4'd3);
        chk("ce_hr_field", 4'(edit_field), 4'd3);
        rst_v = 1'b1; run(1); rst_v = 1'b0;
        run(1);
        chk("rst_disp", 4'(disp_sel), 4'd0);
        chk("rst_field", 4'(edit_field), 4'd0);
        run(12);

        // Countdown run, expiry and acknowledge
        press(3'b100, 8);
        cz_v = 1'b0;
        d0 = n_dec;
        press(3'b010, 8);
        run(35);
        chk("dec_seen", 4'(n_dec - d0 >= 3), 4'd1);
        cz_v = 1'b1;
        run(12);
        chk("alarm_set", 4'(alarm_on), 4'd1);
        l0 = n_load;
        press(3'b001, 8);
        chk("alarm_clr", 4'(alarm_on), 4'd0);
        chk("done_disp", 4'(disp_sel), 4'd2);
        chk("done_load", 4'(n_load - l0), 4'd1);
        cz_v = 1'b0;

        // Run / pause / reload
        press(3'b010, 8);
        run(3);
        press(3'b010, 8);
        run(30);
        press(3'b001, 8);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < 3; k++)
                if ($urandom_range(0, 11) == 0) raw_v[k] = !raw_v[k];
            if ($urandom_range(0, 39) == 0) cz_v = !cz_v;
            rst_v = ($urandom_range(0, 1999) == 0);
            step();
        end
        rst_v = 1'b0;
        run(2);
        @(posedge clock);
        #3;
        chk("queue_drained", 4'(expq.size() != 0), 4'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_key_sequencer.md
Name: timer_key_sequencer

Overview:
- Control FSM for the time-of-day / countdown timer datapath.
- Turns the three raw pushbuttons (adjust, start_stop, mode) into debounced press events, and generates the 1 Hz tick and blink phase.
- Issues one-cycle command strobes and select lines to the BCD counter and display datapath, so the counters hold no key-handling logic.

Parameters:
- CLK_HZ, 50000000: clock cycles per second; tick period.
- DEBOUNCE_CYC, 1000000: consecutive stable cycles needed to accept a key level change.
- BLINK_CYC, 25000000: cycles per blink half-period.
- ID_CYC, 100000000: cycles the ID screen is shown after reset.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- key_adjust_n  in  1  raw pushbutton, active-low, asynchronous
- key_start_stop_n  in  1  raw pushbutton, active-low, asynchronous
- key_mode_n  in  1  raw pushbutton, active-low, asynchronous
- cnt_zero  in  1  countdown datapath value is 00:00:00
- disp_sel  out  2  0=ID, 1=time of day, 2=countdown, 3=countdown preset
- edit_field  out  2  0=none, 1=sec, 2=min, 3=hr
- blink  out  1  1 = blank the edited field (all digits in DONE)
- tod_tick  out  1  1-cycle strobe: advance time of day by 1 s
- dec_strobe  out  1  1-cycle strobe: decrement countdown by 1 s
- inc_strobe  out  1  1-cycle strobe: increment edited field (wraps in datapath)
- clr_sec_strobe  out  1  1-cycle strobe: zero time-of-day seconds
- load_strobe  out  1  1-cycle strobe: copy preset into countdown counter
- alarm_on  out  1  countdown expired

Behaviour:
- Reset is synchronous and active-high. Port names are clock and reset.
- Reset values:
  - state = ID; all strobes 0; disp_sel = 0; edit_field = 0; blink = 0; alarm_on = 0.
  - Tick, blink, ID and debounce counters = 0; debounced key levels = 1 (released).
- Reset mid-operation aborts everything immediately, including an edit or a running countdown.
- Key path, per key:
  - 2-FF synchronizer.
  - Debounce counter runs while the synchronized level differs from the debounced level. After DEBOUNCE_CYC consecutive differing cycles the debounced level updates; any agreeing cycle clears the counter.
  - A press event is a 1-cycle pulse on a debounced 1->0 transition. Release generates nothing.
- Event priority when several events fall in the same cycle: mode > start_stop > adjust. Lower-priority events that cycle are dropped.
- Tick counter: counts 0..CLK_HZ-1 and wraps; tick = 1 in the cycle the counter is at CLK_HZ-1. It is free-running and never stopped by state.
- Blink: toggles every BLINK_CYC cycles. Counter and blink are cleared to 0 on every state change, so a newly selected field starts visible.
- All outputs are registered. A strobe appears the cycle after its triggering event or tick, coincident with the state update.
- tod_tick = tick in every state except TE_SEC, TE_MIN, TE_HR; time of day freezes while it is being edited.
- States: ID, TOD, TE_SEC, TE_MIN, TE_HR, CD_IDLE, CD_RUN, CD_PAUSE, CE_MIN, CE_HR, CD_DONE.
  - ID (disp 0): after ID_CYC cycles -> TOD. Keys ignored.
  - TOD (disp 1): mode -> CD_IDLE; adjust -> TE_SEC.
  - TE_SEC (disp 1, field 1): start_stop -> clr_sec_strobe; mode -> TE_MIN; adjust -> TOD.
  - TE_MIN (field 2): start_stop -> inc_strobe; mode -> TE_HR; adjust -> TOD.
  - TE_HR (field 3): start_stop -> inc_strobe; mode -> TE_SEC; adjust -> TOD.
  - CD_IDLE (disp 2): start_stop -> CD_RUN if !cnt_zero, otherwise ignored; adjust -> CE_MIN; mode -> TOD.
  - CD_RUN (disp 2):
    - On tick: if cnt_zero -> CD_DONE with no dec_strobe; otherwise dec_strobe.
    - start_stop -> CD_PAUSE.
    - adjust -> load_strobe, CD_IDLE.
    - mode is ignored.
    - If a tick and a key event coincide, the tick action wins and the event is dropped.
  - CD_PAUSE (disp 2, no decrement): start_stop -> CD_RUN; adjust -> load_strobe, CD_IDLE; mode ignored.
  - CE_MIN (disp 3, field 2): start_stop -> inc_strobe; mode -> CE_HR; adjust -> load_strobe, CD_IDLE.
  - CE_HR (disp 3, field 3): start_stop -> inc_strobe; mode -> CE_MIN; adjust -> load_strobe, CD_IDLE.
  - CD_DONE (disp 2, edit_field 0, alarm_on 1, blink active on all digits): any key event -> load_strobe, alarm_on 0, CD_IDLE.
- At most one of inc_strobe, clr_sec_strobe, load_strobe and dec_strobe is high in any cycle. tod_tick is independent of the others.

Test Plan:
Bench parameters: CLK_HZ=10, DEBOUNCE_CYC=4, BLINK_CYC=5, ID_CYC=8.
- Reset, then hold all keys high -> disp_sel=0 for 8 cycles, then 1. tod_tick pulses every 10 cycles; no other strobe.
- Mode key low for 3 cycles, then high (bounce) -> no event, state TOD. Low for 10 cycles -> exactly one event; disp_sel=2 appears 2 sync + 4 debounce + 1 cycles after the key edge.
- In TOD: adjust, start_stop, mode, start_stop, start_stop, adjust -> clr_sec_strobe ×1 (field 1), inc_strobe ×2 (field 2), back to TOD. No tod_tick during edit states.
- CD_IDLE with cnt_zero=0: start_stop -> dec_strobe once per 10 cycles. Assert cnt_zero -> next tick enters CD_DONE, alarm_on=1, no dec_strobe. Any key -> load_strobe, alarm_on=0, disp_sel=2.
- CD_RUN: start_stop -> CD_PAUSE, no dec_strobe over 30 cycles. Adjust -> load_strobe, CD_IDLE.
- Mode and adjust debounced in the same cycle from TOD -> CD_IDLE (mode wins). Reset asserted in CE_HR -> ID, all outputs at reset values the next cycle.
